// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared widths, FSM state type and dark-bin helper for hist_feature_extract
package hist_pkg;

  localparam int BIN_W    = 6;
  localparam int CNT_W    = 12;
  localparam int NUM_BINS = 2 ** BIN_W;
  localparam int DARK_THR = 16;

  // Accumulator widths sized so a full 64-bin scan can never overflow
  localparam int TOT_W  = CNT_W + BIN_W;
  localparam int WSUM_W = CNT_W + 2 * BIN_W;
  localparam int NZ_W   = BIN_W + 1;
  localparam int PROD_W = CNT_W + BIN_W;

  localparam logic [BIN_W-1:0] LAST_ADDR = BIN_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } hfe_state_e;

  function automatic logic is_dark(input logic [BIN_W-1:0] idx);
    return int'(idx) < DARK_THR;
  endfunction

endpackage

// File: rtl/hfe_peak_tracker.sv
// rtl/hfe_peak_tracker.sv - running peak bin/count; strict compare keeps the lowest index on ties
module hfe_peak_tracker
  import hist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [BIN_W-1:0] idx,
  input  logic [CNT_W-1:0] count,
  output logic [BIN_W-1:0] peak_bin,
  output logic [CNT_W-1:0] peak_count
);

  logic [BIN_W-1:0] peak_bin_q, peak_bin_d;
  logic [CNT_W-1:0] peak_count_q, peak_count_d;

  always_comb begin
    peak_bin_d   = peak_bin_q;
    peak_count_d = peak_count_q;
    if (clear) begin
      peak_bin_d   = '0;
      peak_count_d = '0;
    end else if (en && (count > peak_count_q)) begin
      peak_bin_d   = idx;
      peak_count_d = count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_bin_q   <= '0;
      peak_count_q <= '0;
    end else begin
      peak_bin_q   <= peak_bin_d;
      peak_count_q <= peak_count_d;
    end
  end

  assign peak_bin   = peak_bin_q;
  assign peak_count = peak_count_q;

endmodule

// File: rtl/hist_feature_extract.sv
// rtl/hist_feature_extract.sv - scans 64 histogram bins into a feature vector with valid/ready output
// Optional HIST_CLEAR_EN: zero each bin in its data cycle so the next image starts clean.
module hist_feature_extract
  import hist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [BIN_W-1:0]  rd_addr,
  input  logic [CNT_W-1:0]  rd_data,
  output logic              wr_en,
  output logic [BIN_W-1:0]  wr_addr,
  output logic              busy,
  output logic              feat_valid,
  input  logic              feat_ready,
  output logic [TOT_W-1:0]  total_count,
  output logic [WSUM_W-1:0] weighted_sum,
  output logic [BIN_W-1:0]  peak_bin,
  output logic [CNT_W-1:0]  peak_count,
  output logic [TOT_W-1:0]  dark_count,
  output logic [NZ_W-1:0]   nonzero_bins
);

  hfe_state_e       state_q;
  logic             rd_en_q, busy_q, feat_valid_q;
  logic [BIN_W-1:0] rd_addr_q;
  logic             vld_q;
  logic [BIN_W-1:0] idx_q;
  logic             clr;

  logic [TOT_W-1:0]  total_q, total_d;
  logic [WSUM_W-1:0] wsum_q, wsum_d;
  logic [TOT_W-1:0]  dark_q, dark_d;
  logic [NZ_W-1:0]   nz_q, nz_d;
  logic [PROD_W-1:0] prod;

  assign clr = start && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      busy_q       <= 1'b0;
      feat_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= READ;
          rd_en_q   <= 1'b1;
          rd_addr_q <= '0;
          busy_q    <= 1'b1;
        end
        READ: if (rd_addr_q == LAST_ADDR) begin
          state_q <= DRAIN;
          rd_en_q <= 1'b0;
        end else begin
          rd_addr_q <= rd_addr_q + BIN_W'(1);
        end
        DRAIN: begin
          state_q      <= DONE;
          feat_valid_q <= 1'b1;
        end
        DONE: if (feat_ready) begin
          state_q      <= IDLE;
          feat_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // rd_data belongs to the address issued one cycle earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      idx_q <= '0;
    end else begin
      vld_q <= rd_en_q;
      idx_q <= rd_addr_q;
    end
  end

  assign prod = {{CNT_W{1'b0}}, idx_q} * {{BIN_W{1'b0}}, rd_data};

  always_comb begin
    total_d = total_q;
    wsum_d  = wsum_q;
    dark_d  = dark_q;
    nz_d    = nz_q;
    if (clr) begin
      total_d = '0;
      wsum_d  = '0;
      dark_d  = '0;
      nz_d    = '0;
    end else if (vld_q) begin
      total_d = total_q + {{BIN_W{1'b0}}, rd_data};
      wsum_d  = wsum_q + {{BIN_W{1'b0}}, prod};
      if (is_dark(idx_q)) dark_d = dark_q + {{BIN_W{1'b0}}, rd_data};
      nz_d = nz_q + {{BIN_W{1'b0}}, (rd_data != '0)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
      wsum_q  <= '0;
      dark_q  <= '0;
      nz_q    <= '0;
    end else begin
      total_q <= total_d;
      wsum_q  <= wsum_d;
      dark_q  <= dark_d;
      nz_q    <= nz_d;
    end
  end

  hfe_peak_tracker u_peak (
    .clk        (clk),
    .rst        (rst),
    .clear      (clr),
    .en         (vld_q),
    .idx        (idx_q),
    .count      (rd_data),
    .peak_bin   (peak_bin),
    .peak_count (peak_count)
  );

`ifdef HIST_CLEAR_EN
  assign wr_en   = vld_q;
  assign wr_addr = idx_q;
`else
  assign wr_en   = 1'b0;
  assign wr_addr = '0;
`endif

  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign busy         = busy_q;
  assign feat_valid   = feat_valid_q;
  assign total_count  = total_q;
  assign weighted_sum = wsum_q;
  assign dark_count   = dark_q;
  assign nonzero_bins = nz_q;

endmodule

// File: tb/tb_hist_feature_extract.sv
// tb/tb_hist_feature_extract.sv - directed-vector bench for hist_feature_extract with a BRAM model
module tb_hist_feature_extract;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [11:0] rd_data = '0;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic        busy;
  logic        feat_valid;
  logic        feat_ready = 1'b0;
  logic [17:0] total_count;
  logic [23:0] weighted_sum;
  logic [5:0]  peak_bin;
  logic [11:0] peak_count;
  logic [17:0] dark_count;
  logic [6:0]  nonzero_bins;

  logic [11:0] mem [64];
  logic [11:0] img [64];
  logic        load_en = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [11:0] load_val = '0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Read-first BRAM model: read data registered, clear write lands after the read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[rd_addr];
    if (load_en) mem[load_addr] <= load_val;
    else if (wr_en) mem[wr_addr] <= '0;
    if (wr_en) wr_cnt <= wr_cnt + 1;
  end

  hist_feature_extract dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .busy         (busy),
    .feat_valid   (feat_valid),
    .feat_ready   (feat_ready),
    .total_count  (total_count),
    .weighted_sum (weighted_sum),
    .peak_bin     (peak_bin),
    .peak_count   (peak_count),
    .dark_count   (dark_count),
    .nonzero_bins (nonzero_bins)
  );

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = '0;
  endtask

  task automatic load_img();
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      load_en = 1'b1; load_addr = 6'(i); load_val = img[i];
    end
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Pulses start and returns the cycle (relative to start) of the first feat_valid, -1 on timeout
  task automatic run_scan(output int lat);
    int c0;
    @(posedge clk); #1;
    start = 1'b1; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (feat_valid) begin lat = cyc - c0; break; end
    end
  endtask

  task automatic accept();
    @(posedge clk); #1;
    feat_ready = 1'b1;
    @(posedge clk); #1;
    feat_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if ({rd_en, busy, feat_valid, wr_en} !== 4'b0) begin n_err++; $display("FAIL reset_ctrl got %b want 0000", {rd_en, busy, feat_valid, wr_en}); end
    n_vec++; if ({total_count, weighted_sum, dark_count, nonzero_bins} !== '0) begin n_err++; $display("FAIL reset_sums got %0d/%0d/%0d/%0d want 0", total_count, weighted_sum, dark_count, nonzero_bins); end
    n_vec++; if ({peak_bin, peak_count} !== '0) begin n_err++; $display("FAIL reset_peak got %0d/%0d want 0/0", peak_bin, peak_count); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_two_bin();
    int lat, wc0, nzmem;
    clear_img(); img[10] = 12'd4095; img[0] = 12'd1;
    load_img();
    wc0 = wr_cnt;
    run_scan(lat);
    n_vec++; if (lat != 66) begin n_err++; $display("FAIL two_bin_latency got %0d want 66", lat); end
    n_vec++; if (total_count !== 18'd4096) begin n_err++; $display("FAIL two_bin_total got %0d want 4096", total_count); end
    n_vec++; if (weighted_sum !== 24'd40950) begin n_err++; $display("FAIL two_bin_wsum got %0d want 40950", weighted_sum); end
    n_vec++; if (peak_bin !== 6'd10) begin n_err++; $display("FAIL two_bin_peak_bin got %0d want 10", peak_bin); end
    n_vec++; if (peak_count !== 12'd4095) begin n_err++; $display("FAIL two_bin_peak_count got %0d want 4095", peak_count); end
    n_vec++; if (dark_count !== 18'd4096) begin n_err++; $display("FAIL two_bin_dark got %0d want 4096", dark_count); end
    n_vec++; if (nonzero_bins !== 7'd2) begin n_err++; $display("FAIL two_bin_nonzero got %0d want 2", nonzero_bins); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL two_bin_busy_done got %b want 1", busy); end
    accept();
    n_vec++; if ({feat_valid, busy} !== 2'b00) begin n_err++; $display("FAIL two_bin_idle got %b want 00", {feat_valid, busy}); end
    n_vec++; if (total_count !== 18'd4096) begin n_err++; $display("FAIL two_bin_hold_total got %0d want 4096", total_count); end
    nzmem = 0;
    for (int i = 0; i < 64; i++) if (mem[i] != 0) nzmem++;
`ifdef HIST_CLEAR_EN
    n_vec++; if (wr_cnt - wc0 != 64) begin n_err++; $display("FAIL clear_wr_cycles got %0d want 64", wr_cnt - wc0); end
    n_vec++; if (nzmem != 0) begin n_err++; $display("FAIL clear_bins_left got %0d want 0", nzmem); end
`else
    n_vec++; if (wr_cnt - wc0 != 0) begin n_err++; $display("FAIL noclear_wr_cycles got %0d want 0", wr_cnt - wc0); end
    n_vec++; if (nzmem != 2) begin n_err++; $display("FAIL noclear_bins_kept got %0d want 2", nzmem); end
`endif
  endtask

  task automatic test_tie();
    int lat;
    clear_img(); img[5] = 12'd200; img[40] = 12'd200;
    load_img();
    run_scan(lat);
    n_vec++; if (lat != 66) begin n_err++; $display("FAIL tie_latency got %0d want 66", lat); end
    n_vec++; if (peak_bin !== 6'd5) begin n_err++; $display("FAIL tie_peak_bin got %0d want 5", peak_bin); end
    n_vec++; if (peak_count !== 12'd200) begin n_err++; $display("FAIL tie_peak_count got %0d want 200", peak_count); end
    n_vec++; if (dark_count !== 18'd200) begin n_err++; $display("FAIL tie_dark got %0d want 200", dark_count); end
    n_vec++; if (total_count !== 18'd400) begin n_err++; $display("FAIL tie_total got %0d want 400", total_count); end
    n_vec++; if (weighted_sum !== 24'd9000) begin n_err++; $display("FAIL tie_wsum got %0d want 9000", weighted_sum); end
    n_vec++; if (nonzero_bins !== 7'd2) begin n_err++; $display("FAIL tie_nonzero got %0d want 2", nonzero_bins); end
    accept();
  endtask

  task automatic test_all_zero();
    int lat;
    clear_img();
    load_img();
    run_scan(lat);
    n_vec++; if (lat != 66) begin n_err++; $display("FAIL zero_latency got %0d want 66", lat); end
    n_vec++; if ({total_count, weighted_sum, dark_count, nonzero_bins} !== '0) begin n_err++; $display("FAIL zero_sums got %0d/%0d/%0d/%0d want 0", total_count, weighted_sum, dark_count, nonzero_bins); end
    n_vec++; if ({peak_bin, peak_count} !== '0) begin n_err++; $display("FAIL zero_peak got %0d/%0d want 0/0", peak_bin, peak_count); end
    accept();
  endtask

  task automatic test_backpressure();
    int lat, bad;
    for (int i = 0; i < 64; i++) img[i] = 12'(i + 1);
    load_img();
    run_scan(lat);
    n_vec++; if (lat != 66) begin n_err++; $display("FAIL ramp_latency got %0d want 66", lat); end
    n_vec++; if (total_count !== 18'd2080) begin n_err++; $display("FAIL ramp_total got %0d want 2080", total_count); end
    n_vec++; if (weighted_sum !== 24'd87360) begin n_err++; $display("FAIL ramp_wsum got %0d want 87360", weighted_sum); end
    n_vec++; if ({peak_bin, peak_count} !== {6'd63, 12'd64}) begin n_err++; $display("FAIL ramp_peak got %0d/%0d want 63/64", peak_bin, peak_count); end
    n_vec++; if (dark_count !== 18'd136) begin n_err++; $display("FAIL ramp_dark got %0d want 136", dark_count); end
    n_vec++; if (nonzero_bins !== 7'd64) begin n_err++; $display("FAIL ramp_nonzero got %0d want 64", nonzero_bins); end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      start = (k == 5);
      @(negedge clk);
      if (!(feat_valid === 1'b1 && busy === 1'b1 && rd_en === 1'b0 && total_count === 18'd2080 && peak_bin === 6'd63)) bad++;
    end
    start = 1'b0;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL stall_stable got %0d bad cycles want 0", bad); end
    @(posedge clk); #1;
    feat_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    feat_ready = 1'b0; start = 1'b0;
    @(negedge clk);
    n_vec++; if ({feat_valid, busy, rd_en} !== 3'b000) begin n_err++; $display("FAIL handshake_idle got %b want 000", {feat_valid, busy, rd_en}); end
    n_vec++; if (weighted_sum !== 24'd87360) begin n_err++; $display("FAIL handshake_hold got %0d want 87360", weighted_sum); end
    @(negedge clk);
    n_vec++; if ({busy, rd_en} !== 2'b00) begin n_err++; $display("FAIL handshake_start_ignored got %b want 00", {busy, rd_en}); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, seen;
    clear_img(); img[10] = 12'd4095; img[0] = 12'd1;
    load_img();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    n_vec++; if (rd_en !== 1'b1) begin n_err++; $display("FAIL midscan_running got %b want 1", rd_en); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if ({rd_en, feat_valid, busy} !== 3'b000) begin n_err++; $display("FAIL midscan_abort got %b want 000", {rd_en, feat_valid, busy}); end
    n_vec++; if (total_count !== 18'd0) begin n_err++; $display("FAIL midscan_total got %0d want 0", total_count); end
    seen = 0;
    repeat (70) begin @(negedge clk); if (feat_valid !== 1'b0 || rd_en !== 1'b0) seen++; end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL midscan_quiet got %0d active cycles want 0", seen); end
    load_img();
    run_scan(lat);
    n_vec++; if (lat != 66) begin n_err++; $display("FAIL rescan_latency got %0d want 66", lat); end
    n_vec++; if (total_count !== 18'd4096) begin n_err++; $display("FAIL rescan_total got %0d want 4096", total_count); end
    n_vec++; if (weighted_sum !== 24'd40950) begin n_err++; $display("FAIL rescan_wsum got %0d want 40950", weighted_sum); end
    n_vec++; if ({peak_bin, nonzero_bins} !== {6'd10, 7'd2}) begin n_err++; $display("FAIL rescan_peak_nz got %0d/%0d want 10/2", peak_bin, nonzero_bins); end
    accept();
  endtask

  initial begin
    test_reset();
    test_two_bin();
    test_tie();
    test_all_zero();
    test_backpressure();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hist_feature_extract.md
Name: hist_feature_extract

Overview:
- Downstream consumer of histogram_bram in the decision-tree malaria pipeline.
- On the histogram's done pulse, it reads all 64 bins through a 1-cycle-latency BRAM read port and reduces them to a fixed feature vector: total, weighted sum, peak bin, dark-pixel count and nonzero-bin count.
- It presents the vector to the decision-tree classifier with a valid/ready handshake.

Parameters:
- BIN_W, 6, bin address width; NUM_BINS = 2**BIN_W = 64.
- CNT_W, 12, width of one histogram bin count.
- DARK_THR, 16, bins with index < DARK_THR count as dark (stained) pixels.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse, driven by done_histogram.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  BIN_W  BRAM bin address.
- rd_data  in  CNT_W  bin count, valid the cycle after rd_en.
- wr_en  out  1  bin clear write enable (HIST_CLEAR_EN only).
- wr_addr  out  BIN_W  bin clear address (HIST_CLEAR_EN only).
- busy  out  1  high from the cycle after start until the handshake completes.
- feat_valid  out  1  feature vector valid.
- feat_ready  in  1  classifier accepts the vector.
- total_count  out  CNT_W+BIN_W  sum of all bins.
- weighted_sum  out  CNT_W+2*BIN_W  sum of bin_index*bin_count.
- peak_bin  out  BIN_W  index of the largest bin.
- peak_count  out  CNT_W  count held in peak_bin.
- dark_count  out  CNT_W+BIN_W  sum of bins with index < DARK_THR.
- nonzero_bins  out  BIN_W+1  number of bins with count != 0.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-scan abandons the scan; no partial vector is ever presented.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 clears all accumulators and moves to READ.
  - start while not IDLE is ignored, with no restart.
- READ:
  - rd_en=1 and rd_addr increments 0..63, one bin per cycle.
  - After addr 63 is issued, go to DRAIN.
- DRAIN: one cycle that accumulates bin 63, then go to DONE.
- Accumulation: each cycle after a read, the returned rd_data is folded into all accumulators, indexed by a 1-cycle-delayed address register.
- Timing: start sampled in cycle 0 -> rd_en high in cycles 1..64 -> data in cycles 2..65 -> feat_valid=1 in cycle 66.
- Arithmetic:
  - Unsigned throughout; widths are sized so no accumulator can overflow.
  - Multiply is index*count, zero-extended.
- Peak selection:
  - Update only when count > peak_count (strict), so ties keep the lowest index.
  - An all-zero histogram gives peak_bin=0, peak_count=0.
- DONE:
  - feat_valid=1 and all feature outputs held stable.
  - On feat_valid&&feat_ready, go to IDLE the next cycle with feat_valid=0 and busy=0. Feature outputs keep their last value.
  - start in the same cycle as the handshake is ignored.
- busy=1 in READ, DRAIN and DONE.

Optional Feature:
- Macro: HIST_CLEAR_EN.
- Defined:
  - Each bin is zeroed so the next image starts clean.
  - wr_en pulses with wr_addr = the delayed read address in the data cycle, i.e. cycles 2..65.
  - Assumes the BRAM is read-first or uses separate ports.
- Undefined: wr_en and wr_addr are tied to 0, and the histogram must be cleared externally.

Decomposition:
- Package hist_pkg: BIN_W, CNT_W, NUM_BINS, DARK_THR defaults, the FSM state enum, and the derived accumulator widths.
- One natural sub-module: hfe_peak_tracker. It holds peak_bin/peak_count with the strict-greater compare and clears on start.

Test Plan:
- Two-bin histogram: bin10=4095, bin0=1. Expect total 4096, weighted_sum 40950, peak_bin 10, peak_count 4095, dark_count 4096, nonzero 2, feat_valid in cycle 66.
- Tie: bin5=bin40=200, all others 0. Expect peak_bin 5, dark_count 200, total 400, weighted_sum 9000.
- All-zero histogram: all features 0, peak_bin 0, feat_valid still asserted in cycle 66.
- Backpressure: feat_ready held low 20 cycles. Expect feat_valid and the outputs stable, a second start ignored, and IDLE one cycle after ready.
- Reset mid-scan: rst at cycle 30. Expect rd_en=0 and feat_valid=0 next cycle; a fresh start produces a correct vector.
- HIST_CLEAR_EN: after the scan, every model bin reads 0 and wr_en was high exactly 64 cycles; without the macro, wr_en is never high.
